// File: rtl/scroller_pkg.sv
// Shared types and constants for the message scroller: FSM encoding,
// display code values and the default message.
package scroller_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [3:0] CODE_Y     = 4'hA;
  localparam logic [3:0] CODE_I     = 4'hB;
  localparam logic [3:0] CODE_M     = 4'hC;
  localparam logic [3:0] CODE_I2    = 4'hD;
  localparam logic [3:0] CODE_N     = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam int unsigned DEFAULT_NUM_DIGITS = 4;
  localparam int unsigned DEFAULT_MSG_LEN    = 8;
  localparam int unsigned DEFAULT_TICK_DIV   = 50_000_000;
  localparam logic [31:0] DEFAULT_MSG        = {CODE_Y, CODE_I, CODE_M, CODE_I2,
                                                CODE_N, CODE_BLANK, CODE_BLANK, CODE_BLANK};

endpackage

// File: rtl/message_scroller_if.sv
// Control and display bundle between the scroller and its user/decoders.
interface message_scroller_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned POS_W      = 3
);

  logic                    run;
  logic                    step;
  logic                    dir;
  logic                    clear;
  logic [NUM_DIGITS*4-1:0] digits;
  logic [POS_W-1:0]        pos;
  logic                    wrap;
  logic [1:0]              state;

  modport master (
    output run, step, dir, clear,
    input  digits, pos, wrap, state
  );

  modport slave (
    input  run, step, dir, clear,
    output digits, pos, wrap, state
  );

endinterface

// File: rtl/scroll_tick_gen.sv
// Auto-scroll prescaler: one-cycle tick every TICK_DIV enabled cycles,
// count held at zero while disabled.
module scroll_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!en || count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Gated so a stale terminal count in the cycle en drops cannot pulse.
  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/message_scroller.sv
// Scrolling window over a fixed message of display codes; feeds one
// nibble per seven-segment decoder, auto or manual stepping with wrap.
module message_scroller
  import scroller_pkg::*;
#(
  parameter int unsigned              NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int unsigned              MSG_LEN    = DEFAULT_MSG_LEN,
  parameter logic [MSG_LEN*4-1:0]     MSG        = DEFAULT_MSG,
  parameter int unsigned              TICK_DIV   = DEFAULT_TICK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  message_scroller_if.slave  bus
);

  localparam int unsigned      POS_W     = $clog2(MSG_LEN);
  localparam int unsigned      DIG_W     = NUM_DIGITS * 4;
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(MSG_LEN - 1);
  localparam logic [DIG_W-1:0] ALL_BLANK = {NUM_DIGITS{CODE_BLANK}};

  state_e             state_q, state_n;
  logic [POS_W-1:0]   pos_q, pos_n;
  logic [DIG_W-1:0]   digits_q, digits_n;
  logic               wrap_q, wrap_n;
  logic               step_d;
  logic               step_edge;
  logic               tick;
  logic [POS_W-1:0]   adv_pos;
  logic               adv_wrap;

  // Leftmost display (MS nibble) shows code[p]; each display rightwards the next code.
  function automatic logic [DIG_W-1:0] window_at(input logic [POS_W-1:0] p);
    logic [DIG_W-1:0] w;
    int unsigned      idx;
    w = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx          = (32'(p) + NUM_DIGITS - 1 - k) % MSG_LEN;
      w[4*k +: 4]  = MSG[4*(MSG_LEN-1-idx) +: 4];
    end
    return w;
  endfunction

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_RUN),
    .tick  (tick)
  );

  assign step_edge = bus.step & ~step_d;

  // Candidate next position for an advance event, direction sampled now.
  always_comb begin
    adv_pos  = pos_q;
    adv_wrap = 1'b0;
    if (!bus.dir) begin
      if (pos_q == LAST_POS) begin
        adv_pos  = '0;
        adv_wrap = 1'b1;
      end else begin
        adv_pos = pos_q + POS_W'(1);
      end
    end else begin
      if (pos_q == '0) begin
        adv_pos  = LAST_POS;
        adv_wrap = 1'b1;
      end else begin
        adv_pos = pos_q - POS_W'(1);
      end
    end
  end

  // Next-state and next-output logic; clear outranks everything else.
  always_comb begin
    state_n  = state_q;
    pos_n    = pos_q;
    digits_n = digits_q;
    wrap_n   = 1'b0;

    if (bus.clear) begin
      state_n  = ST_BLANK;
      pos_n    = '0;
      digits_n = ALL_BLANK;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          digits_n = ALL_BLANK;
          if (bus.run || step_edge) begin
            state_n  = bus.run ? ST_RUN : ST_HOLD;
            pos_n    = '0;
            digits_n = window_at('0);
          end
        end
        ST_RUN: begin
          if (!bus.run) begin
            state_n = ST_HOLD;
          end else if (tick) begin
            pos_n    = adv_pos;
            wrap_n   = adv_wrap;
            digits_n = window_at(adv_pos);
          end
        end
        ST_HOLD: begin
          if (bus.run) begin
            state_n = ST_RUN;
          end else if (step_edge) begin
            pos_n    = adv_pos;
            wrap_n   = adv_wrap;
            digits_n = window_at(adv_pos);
          end
        end
        default: begin
          state_n  = ST_BLANK;
          pos_n    = '0;
          digits_n = ALL_BLANK;
        end
      endcase
    end
  end

  // step_d resets high so a step held through reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_BLANK;
      pos_q    <= '0;
      digits_q <= ALL_BLANK;
      wrap_q   <= 1'b0;
      step_d   <= 1'b1;
    end else begin
      state_q  <= state_n;
      pos_q    <= pos_n;
      digits_q <= digits_n;
      wrap_q   <= wrap_n;
      step_d   <= bus.step;
    end
  end

  assign bus.digits = digits_q;
  assign bus.pos    = pos_q;
  assign bus.wrap   = wrap_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_message_scroller.sv
// Directed plus randomized bench for message_scroller against a
// cycle-level behavioural model of mode, position and scroll period.
module tb_message_scroller;
  import scroller_pkg::*;

  localparam int unsigned ND = 4;
  localparam int unsigned ML = 8;
  localparam int unsigned TD = 4;
  localparam int unsigned PW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  message_scroller_if #(.NUM_DIGITS(ND), .POS_W(PW)) bus ();

  message_scroller #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .MSG        (32'hABCDEFFF),
    .TICK_DIV   (TD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 blank, 1 auto, 2 manual; position; cycles spent in auto since last step.
  int       m_mode;
  int       m_pos;
  int       m_cnt;
  int       m_wrap;
  bit       m_step_prev;
  logic [3:0] codes [ML] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'hF, 4'hF};

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_cnt = 0; m_wrap = 0; m_step_prev = 1'b1;
  endtask

  task automatic model_move();
    int np;
    np = m_pos + (bus.dir ? -1 : 1);
    if (np < 0)   begin np = np + ML; m_wrap = 1; end
    if (np >= ML) begin np = np - ML; m_wrap = 1; end
    m_pos = np;
  endtask

  task automatic model_edge();
    bit rise, due;
    if (reset) begin
      model_reset();
      return;
    end
    rise        = bus.step && !m_step_prev;
    due         = (m_mode == 1) && (m_cnt == TD - 1);
    m_cnt       = (m_mode == 1 && !due) ? m_cnt + 1 : 0;
    m_wrap      = 0;
    m_step_prev = bus.step;
    if (bus.clear) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 0) begin
      if (bus.run) m_mode = 1;
      else if (rise) m_mode = 2;
      m_pos = 0;
    end else if (m_mode == 1) begin
      if (!bus.run) m_mode = 2;
      else if (due) model_move();
    end else begin
      if (bus.run) m_mode = 1;
      else if (rise) model_move();
    end
  endtask

  function automatic logic [15:0] exp_digits();
    logic [15:0] r;
    r = 16'hFFFF;
    if (m_mode != 0)
      for (int j = 0; j < ND; j++) r[4*(ND-1-j) +: 4] = codes[(m_pos + j) % ML];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".digits"}, 32'(bus.digits), 32'(exp_digits()));
    chk({tag, ".pos"},    32'(bus.pos),    32'(m_pos));
    chk({tag, ".wrap"},   32'(bus.wrap),   32'(m_wrap));
    chk({tag, ".state"},  32'(bus.state),  32'(m_mode));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse(input string tag);
    bus.step = 1'b1; cycle(tag);
    bus.step = 1'b0; cycle(tag);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.run = 1'b0; bus.step = 1'b0; bus.dir = 1'b0; bus.clear = 1'b0;
    model_reset();
    #12;
    check_all("por");
    reset = 1'b0;
    repeat (2) cycle("idle");

    // Auto-scroll entry and period
    bus.run = 1'b1;
    cycle("t2_enter");
    chk("t2_abcd", 32'(bus.digits), 32'h0000ABCD);
    repeat (TD) cycle("t2_run");
    chk("t2_pos1", 32'(bus.pos), 32'd1);
    chk("t2_bcde", 32'(bus.digits), 32'h0000BCDE);

    // Tail of message and wrap
    n = 0; while (m_pos != 6 && n < 100) begin cycle("t3_run"); n++; end
    chk("t3_ffab", 32'(bus.digits), 32'h0000FFAB);
    n = 0; while (m_pos != 7 && n < 100) begin cycle("t3_run"); n++; end
    chk("t3_fabc", 32'(bus.digits), 32'h0000FABC);
    n = 0; while (m_pos != 0 && n < 100) begin cycle("t3_run"); n++; end
    chk("t3_wrap", 32'(bus.wrap), 32'd1);
    cycle("t3_after");
    chk("t3_wrap_once", 32'(bus.wrap), 32'd0);

    // Drop run coincident with a tick at pos 2
    n = 0;
    while (!(m_pos == 2 && m_mode == 1 && m_cnt == TD - 1) && n < 200) begin cycle("t4_seek"); n++; end
    chk("t4_seek_ok", 32'(n < 200), 32'd1);
    bus.run = 1'b0;
    cycle("t4_drop");
    chk("t4_cdef", 32'(bus.digits), 32'h0000CDEF);
    repeat (20) cycle("t4_hold");
    pulse("t4_fwd");
    chk("t4_deff", 32'(bus.digits), 32'h0000DEFF);
    bus.dir = 1'b1;
    pulse("t4_back");
    chk("t4_pos2", 32'(bus.pos), 32'd2);
    bus.dir = 1'b0; bus.step = 1'b1;
    repeat (10) cycle("t4_held");
    bus.step = 1'b0;
    cycle("t4_rel");
    chk("t4_pos3", 32'(bus.pos), 32'd3);

    // Retreat through zero, then clear beats run and step
    bus.dir = 1'b1;
    repeat (3) pulse("t5_back");
    bus.step = 1'b1;
    cycle("t5_wrap");
    chk("t5_fabc", 32'(bus.digits), 32'h0000FABC);
    chk("t5_wrap1", 32'(bus.wrap), 32'd1);
    bus.step = 1'b0;
    cycle("t5_idle");
    bus.clear = 1'b1; bus.run = 1'b1; bus.step = 1'b1;
    cycle("t5_clear");
    chk("t5_blank", 32'(bus.digits), 32'h0000FFFF);
    bus.clear = 1'b0; bus.run = 1'b0;

    // Step held high across reset release
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("t6_rst");
    cycle("t6_rst_edge");
    reset = 1'b0;
    repeat (3) cycle("t6_held");
    chk("t6_blank", 32'(bus.state), 32'd0);
    bus.step = 1'b0;
    cycle("t6_rel");
    bus.step = 1'b1;
    cycle("t6_step");
    chk("t6_abcd", 32'(bus.digits), 32'h0000ABCD);
    bus.step = 1'b0;
    cycle("t6_done");

    // Async reset mid-scroll
    bus.dir = 1'b0; bus.run = 1'b1;
    n = 0; while (!(m_pos == 3 && m_mode == 1) && n < 100) begin cycle("t1_seek"); n++; end
    #2 reset = 1'b1;
    #1 model_reset();
    chk("t1_async_digits", 32'(bus.digits), 32'h0000FFFF);
    check_all("t1_async");
    bus.run = 1'b0;
    reset = 1'b0;
    repeat (5) cycle("t1_quiet");

    // Randomized mix
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 6) bus.run = ~bus.run;
      bus.step  = ($urandom_range(0, 1) == 1);
      bus.dir   = ($urandom_range(0, 1) == 1);
      bus.clear = ($urandom_range(0, 99) < 2);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
